// File: rtl/traffic_pkg.sv
// Shared traffic definitions: phase encoding, lamp codes and default phase lengths.
package traffic_pkg;

  typedef enum logic [2:0] {G0, Y0, AR0, G1, Y1, AR1} state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int GREEN_T_DEF  = 5;
  localparam int YELLOW_T_DEF = 2;
  localparam int ALLRED_T_DEF = 1;

  function automatic state_t next_state(input state_t s);
    case (s)
      G0:      next_state = Y0;
      Y0:      next_state = AR0;
      AR0:     next_state = G1;
      G1:      next_state = Y1;
      Y1:      next_state = AR1;
      default: next_state = G0;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 3-bit down-counter with enable; stops at zero and flags it.
module phase_timer #(
  parameter logic [2:0] RST_VAL = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic [2:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= RST_VAL;
    else if (load)           cnt <= load_val;
    else if (en && cnt != 0) cnt <= cnt - 3'd1;
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection controller: six-phase light cycle with pedestrian green shortening.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       hold,
  output logic [2:0] light0,
  output logic [2:0] light1,
  output logic [2:0] count0,
  output logic [2:0] count1,
  output logic       pattern0,
  output logic       pattern1
);

  state_t     state, state_nxt;
  logic       ped_pending, ped_nxt;
  logic       load, en, zero, accepted;
  logic [2:0] load_val, cnt;

  function automatic logic [2:0] phase_max(input state_t s);
    case (s)
      G0, G1:  phase_max = 3'(GREEN_T - 1);
      Y0, Y1:  phase_max = 3'(YELLOW_T - 1);
      default: phase_max = 3'(ALLRED_T - 1);
    endcase
  endfunction

  assign accepted = tick && !hold;

  phase_timer #(.RST_VAL(3'(ALLRED_T - 1))) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= AR1;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      ped_pending <= ped_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = 3'd0;
    en        = 1'b0;
    ped_nxt   = ped_pending || ped_req;
    if (accepted) begin
      if (zero) begin
        state_nxt = next_state(state);
        load      = 1'b1;
        load_val  = phase_max(state_nxt);
        // Entering all-red consumes the request; a request on this edge survives.
        if (state_nxt == AR0 || state_nxt == AR1) ped_nxt = ped_req;
      end else if ((state == G0 || state == G1) && ped_pending && cnt >= 3'd2) begin
        load     = 1'b1;
        load_val = 3'd1;
      end else begin
        en = 1'b1;
      end
    end
  end

  always_comb begin
    light0   = RED;
    light1   = RED;
    count0   = 3'd0;
    count1   = 3'd0;
    pattern0 = 1'b0;
    pattern1 = 1'b0;
    case (state)
      G0: begin light0 = GREEN;  count0 = cnt + 3'd1; pattern1 = 1'b1; end
      Y0: begin light0 = YELLOW; count0 = cnt + 3'd1; end
      G1: begin light1 = GREEN;  count1 = cnt + 3'd1; pattern0 = 1'b1; end
      Y1: begin light1 = YELLOW; count1 = cnt + 3'd1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized and directed bench for intersection_ctrl against a phase/seconds-remaining model.
module tb_intersection_ctrl;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  localparam int GT = 5, YT = 2, AT = 1;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, ped_req = 1'b0, hold = 1'b0;
  logic [2:0] light0, light1, count0, count1;
  logic       pattern0, pattern1;

  int checks = 0, passes = 0;
  int lens [6] = '{GT, YT, AT, GT, YT, AT};
  int ph, rem;
  bit pend;
  int acc_ticks = 0, last_g0 = -1, periods = 0;
  logic [2:0] prev_l0 = R;

  intersection_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .hold(hold),
    .light0(light0), .light1(light1), .count0(count0), .count1(count1),
    .pattern0(pattern0), .pattern1(pattern1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    ph = 5; rem = AT - 1; pend = 0;
  endtask

  // Phase index 0..5 = G0,Y0,AR0,G1,Y1,AR1; rem = seconds left minus one.
  task automatic model_edge(input bit t, input bit h, input bit p);
    bit np;
    np = pend;
    if (t && !h) begin
      acc_ticks++;
      if (rem == 0) begin
        ph = (ph + 1) % 6;
        rem = lens[ph] - 1;
        if (ph == 2 || ph == 5) np = 0;
      end else if ((ph == 0 || ph == 3) && pend && rem >= 2) rem = 1;
      else rem = rem - 1;
    end
    pend = np | p;
  endtask

  task automatic check_all();
    logic [2:0] e0, e1, c0, c1;
    e0 = (ph == 0) ? G : (ph == 1) ? Y : R;
    e1 = (ph == 3) ? G : (ph == 4) ? Y : R;
    c0 = (ph <= 1) ? 3'(rem + 1) : 3'd0;
    c1 = (ph == 3 || ph == 4) ? 3'(rem + 1) : 3'd0;
    chk("light0", {5'd0, light0}, {5'd0, e0});
    chk("light1", {5'd0, light1}, {5'd0, e1});
    chk("count0", {5'd0, count0}, {5'd0, c0});
    chk("count1", {5'd0, count1}, {5'd0, c1});
    chk("pattern0", {7'd0, pattern0}, {7'd0, ph == 3});
    chk("pattern1", {7'd0, pattern1}, {7'd0, ph == 0});
    chk("one_dir_only", {7'd0, (light0 == R) || (light1 == R)}, 8'd1);
  endtask

  task automatic step(input bit t, input bit h, input bit p);
    tick = t; hold = h; ped_req = p;
    @(posedge clk);
    model_edge(t, h, p);
    #1;
    check_all();
    tick = 0; hold = 0; ped_req = 0;
  endtask

  task automatic run_until(input int tph, input int trem, input bit p);
    int n = 0;
    while (!(ph == tph && (trem < 0 || rem == trem)) && n < 100) begin
      step(1, 0, p);
      n++;
    end
    chk("run_until_reached", {7'd0, n < 100}, 8'd1);
  endtask

  task automatic check_red_reset(input string tag);
    chk({tag, "_lights"}, {2'd0, light0, light1}, {2'd0, R, R});
    chk({tag, "_counts"}, {2'd0, count0, count1}, 8'd0);
    chk({tag, "_patterns"}, {6'd0, pattern0, pattern1}, 8'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_red_reset("in_reset");
    rst = 1;
    #1;
    check_red_reset("after_release");

    step(1, 0, 0);
    chk("first_tick_light0", {5'd0, light0}, {5'd0, G});
    chk("first_tick_light1", {5'd0, light1}, {5'd0, R});
    chk("first_tick_count0", {5'd0, count0}, 8'd5);
    chk("first_tick_pattern1", {7'd0, pattern1}, 8'd1);

    // Free run with idle cycles between ticks; measure G0-to-G0 period in ticks.
    prev_l0 = light0; last_g0 = acc_ticks;
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 3) != 0, 0, 0);
      if (light0 == G && prev_l0 != G) begin
        chk("period_ticks", 8'(acc_ticks - last_g0), 8'(2 * (GT + YT + AT)));
        last_g0 = acc_ticks;
        periods++;
      end
      prev_l0 = light0;
    end
    chk("periods_seen", {7'd0, periods >= 2}, 8'd1);

    // Pedestrian pulse on an idle edge while count0=4 shortens the green.
    run_until(0, 3, 0);
    chk("pre_ped_count0", {5'd0, count0}, 8'd4);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("ped_short_count0", {5'd0, count0}, 8'd2);
    for (int i = 0; i < 3; i++) step(1, 0, 0);

    // Hold in Y0 freezes everything; request during hold is still latched.
    run_until(1, -1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, i == 4);
      chk("hold_y0_light0", {5'd0, light0}, {5'd0, Y});
    end
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Request held through AR0 survives the clear and shortens G1.
    run_until(2, -1, 1);
    step(1, 0, 1);
    chk("g1_entry_light1", {5'd0, light1}, {5'd0, G});
    step(1, 0, 0);
    chk("g1_short_count1", {5'd0, count1}, 8'd2);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("g1_to_y1_light1", {5'd0, light1}, {5'd0, Y});

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);

    // Asynchronous reset mid-G1, between clock edges.
    run_until(3, -1, 0);
    step(1, 0, 0);
    #2 rst = 0;
    #1;
    check_red_reset("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_red_reset("held_reset");
    rst = 1;
    step(0, 0, 0);
    step(1, 0, 0);
    chk("restart_light0", {5'd0, light0}, {5'd0, G});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
